jk_ubus_slave_mem: RTL and testbench

Synthesisable UBUS slave responder backed by an internal register-file memory. It is the parametrised successor to the fixed 8-bit/16-bit slave signal set: data width, address width, address window and depth are parameters, and it adds programmable wait states, burst handling of 1/2/4/8 beats, and error responses. It sits on the UBUS as a DUT-side slave and serves as the reference target for the slave VIP agent.

---
 rtl/jk_ubus_slave_mem.sv | 174 +++++++++++++++++
 tb/tb_jk_ubus_slave_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_ubus_slave_mem.sv
// UBUS slave responder backed by an internal register-file memory: wait states, 1/2/4/8-beat bursts, error responses.
// Define JK_UBUS_SLAVE_STATS_EN to add saturating rd_cnt/wr_cnt/err_cnt ports.
module jk_ubus_slave_mem #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              read,
  input  logic              write,
  input  logic              bip,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  output logic              wait_state,
  output logic              error,
  input  logic [2:0]        wait_cfg
`ifdef JK_UBUS_SLAVE_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       err_cnt
`endif
);
  // state | meaning
  // IDLE  | waiting for an address phase
  // DATA  | serving burst beats: wait cycles, then the completing cycle
  // ERR   | error asserted once per beat of a rejected burst
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  localparam int OFF_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EXT_W = ADDR_W + 2;
  localparam logic [EXT_W-1:0] DEPTH_X = EXT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]       state;
  logic [OFF_W-1:0] offset;
  logic [3:0]       beats;
  logic [2:0]       wcnt;
  logic [2:0]       ecnt;
  logic             dir_wr;

  logic             req;
  logic [3:0]       beats_req;
  logic [EXT_W-1:0] off_full;
  logic [EXT_W-1:0] end_full;
  logic             in_window;
  logic             fits;
  logic [OFF_W-1:0] off_req;
  logic [OFF_W-1:0] offset_nx;
  logic             beat_done;
  logic             last_beat;
  logic             mem_we;

  // Two extra bits keep below-base addresses and window-end overflow out of range.
  always_comb begin
    req       = read ^ write;
    beats_req = 4'd1 << size;
    off_full  = {2'b00, addr} - {2'b00, BASE_ADDR};
    end_full  = off_full + EXT_W'(beats_req);
    in_window = off_full < DEPTH_X;
    fits      = end_full <= DEPTH_X;
    off_req   = off_full[OFF_W-1:0];
    offset_nx = offset + OFF_W'(1);
    beat_done = (state == DATA) && (wcnt == 3'd0);
    last_beat = (beats == 4'd1) || !bip;
    mem_we    = beat_done && dir_wr;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[offset] <= data_in;
  end

  // Outputs are registered for the cycle being entered, so a zero-wait read shows data in N+1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      offset     <= '0;
      beats      <= '0;
      wcnt       <= '0;
      ecnt       <= '0;
      dir_wr     <= 1'b0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      wait_state <= 1'b0;
      error      <= 1'b0;
    end else begin
      data_out   <= '0;
      data_oe    <= 1'b0;
      wait_state <= 1'b0;
      error      <= 1'b0;
      case (state)
        IDLE: begin
          if (req && in_window) begin
            if (fits) begin
              state      <= DATA;
              offset     <= off_req;
              beats      <= beats_req;
              dir_wr     <= write;
              wcnt       <= wait_cfg;
              wait_state <= (wait_cfg != 3'd0);
              if (read && (wait_cfg == 3'd0)) begin
                data_oe  <= 1'b1;
                data_out <= mem[off_req];
              end
            end else begin
              state <= ERR;
              ecnt  <= 3'(beats_req - 4'd1);
              error <= 1'b1;
            end
          end
        end
        DATA: begin
          if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
            if (wcnt == 3'd1) begin
              if (!dir_wr) begin
                data_oe  <= 1'b1;
                data_out <= mem[offset];
              end
            end else begin
              wait_state <= 1'b1;
            end
          end else if (last_beat) begin
            state <= IDLE;
          end else begin
            offset     <= offset_nx;
            beats      <= beats - 4'd1;
            wcnt       <= wait_cfg;
            wait_state <= (wait_cfg != 3'd0);
            if (!dir_wr && (wait_cfg == 3'd0)) begin
              data_oe  <= 1'b1;
              data_out <= mem[offset_nx];
            end
          end
        end
        ERR: begin
          if (ecnt == 3'd0) begin
            state <= IDLE;
          end else begin
            ecnt  <= ecnt - 3'd1;
            error <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_UBUS_SLAVE_STATS_EN
  logic err_enter;
  assign err_enter = (state == IDLE) && req && in_window && !fits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (beat_done && !dir_wr && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
      if (beat_done && dir_wr && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
      if (err_enter && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jk_ubus_slave_mem.sv
// Bench for jk_ubus_slave_mem: a transaction table drives the bus and pushes per-cycle expected outputs to a scoreboard.
`timescale 1ns/1ps
module tb_jk_ubus_slave_mem;
  localparam int          DW    = 8;
  localparam int          AW    = 16;
  localparam int          DEPTH = 256;
  localparam logic [15:0] BASE  = 16'h0000;

  localparam int K_OK  = 0;
  localparam int K_ERR = 1;
  localparam int K_IGN = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] addr;
  logic [1:0]    size;
  logic          read, write, bip;
  logic [DW-1:0] data_in, data_out;
  logic          data_oe, wait_state, error;
  logic [2:0]    wait_cfg;
`ifdef JK_UBUS_SLAVE_STATS_EN
  logic [15:0]   rd_cnt, wr_cnt, err_cnt;
`endif

  jk_ubus_slave_mem #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .size(size), .read(read), .write(write),
    .bip(bip), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .wait_state(wait_state), .error(error), .wait_cfg(wait_cfg)
`ifdef JK_UBUS_SLAVE_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       ws;
    logic       er;
    logic       oe;
    logic [7:0] d;
  } exp_t;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] a;
    logic [1:0]  sz;
    logic [2:0]  wc0;
    logic [2:0]  wcn;
    int          stop_beat;
    int          rst_beat;
    logic [7:0]  wbase;
    logic [7:0]  wstep;
    int          kind;
  } txn_t;

  exp_t       sb[$];
  exp_t       e;
  txn_t       tbl[$];
  logic [7:0] ref_mem [DEPTH];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         rd_exp = 0, wr_exp = 0, err_exp = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic exp_cyc(input logic ws, input logic er, input logic oe, input logic [7:0] d);
    sb.push_back('{cyc, ws, er, oe, d});
  endtask

  // Compare every entry due this cycle at the falling edge, then advance one cycle.
  task automatic tick();
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc == cyc && {wait_state, error, data_oe, data_out} === {e.ws, e.er, e.oe, e.d})
        n_pass++;
      else
        $display("FAIL bus_cyc%0d (due %0d): got ws=%b err=%b oe=%b d=%h want ws=%b err=%b oe=%b d=%h",
                 cyc, e.cyc, wait_state, error, data_oe, data_out, e.ws, e.er, e.oe, e.d);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add(input bit wr, input bit rd, input logic [15:0] a, input logic [1:0] sz,
                     input logic [2:0] wc0, input logic [2:0] wcn, input int stop_beat,
                     input int rst_beat, input logic [7:0] wbase, input logic [7:0] wstep,
                     input int kind);
    tbl.push_back('{wr, rd, a, sz, wc0, wcn, stop_beat, rst_beat, wbase, wstep, kind});
  endtask

  task automatic do_reset_mid();
    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    bip = 1'b0;
    #1;
    chk("rst_mid_async", 32'({wait_state, error, data_oe, data_out}), 32'd0);
    exp_cyc(0, 0, 0, 8'h00);
    tick();
    reset = 1'b0;
    rd_exp = 0;
    wr_exp = 0;
    err_exp = 0;
  endtask

  task automatic do_txn(input txn_t t);
    int nb, nlast, off;
    logic [2:0] wc;
    logic [7:0] d;
    nb    = 1 << t.sz;
    nlast = (t.stop_beat > 0) ? t.stop_beat : nb;
    off   = int'(t.a) - int'(BASE);
    exp_cyc(0, 0, 0, 8'h00);
    addr = t.a; size = t.sz; read = t.rd; write = t.wr;
    wait_cfg = t.wc0; bip = (nb > 1); data_in = 8'($urandom);
    tick();
    read = 1'b0; write = 1'b0; addr = 16'($urandom);
    case (t.kind)
      K_ERR: begin
        err_exp++;
        for (int b = 0; b < nb; b++) begin
          exp_cyc(0, 1, 0, 8'h00);
          data_in = 8'($urandom);
          tick();
        end
      end
      K_IGN: begin
        exp_cyc(0, 0, 0, 8'h00);
        tick();
      end
      default: begin
        for (int b = 0; b < nlast; b++) begin
          wc = (b == 0) ? t.wc0 : t.wcn;
          if (t.rst_beat == b + 1) begin
            do_reset_mid();
            return;
          end
          for (int w = 0; w < int'(wc); w++) begin
            exp_cyc(1, 0, 0, 8'h00);
            wait_cfg = 3'($urandom);
            data_in = 8'($urandom);
            bip = 1'b1;
            tick();
          end
          d = t.wbase + 8'(b) * t.wstep;
          bip = (b != nlast - 1);
          wait_cfg = t.wcn;
          if (t.wr) begin
            data_in = d;
            exp_cyc(0, 0, 0, 8'h00);
            ref_mem[off + b] = d;
            wr_exp++;
          end else begin
            data_in = 8'($urandom);
            exp_cyc(0, 0, 1, ref_mem[off + b]);
            rd_exp++;
          end
          tick();
        end
      end
    endcase
    bip = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    //   wr rd addr     sz wc0 wcn stop rst wbase  wstep kind
    add(1, 0, 16'h0010, 0, 0, 0, 0, 0, 8'hA5, 8'h00, K_OK);
    add(0, 1, 16'h0010, 0, 0, 0, 0, 0, 8'h00, 8'h00, K_OK);
    add(1, 0, 16'h0020, 2, 2, 2, 0, 0, 8'h11, 8'h11, K_OK);
    add(0, 1, 16'h0020, 2, 2, 2, 0, 0, 8'h00, 8'h00, K_OK);
    add(1, 0, 16'h00FC, 2, 1, 0, 0, 0, 8'hC0, 8'h01, K_OK);
    add(0, 1, 16'h00FC, 3, 0, 0, 0, 0, 8'h00, 8'h00, K_ERR);
    add(1, 0, 16'h00FC, 3, 2, 2, 0, 0, 8'h5A, 8'h01, K_ERR);
    add(0, 1, 16'h00FC, 2, 0, 3, 0, 0, 8'h00, 8'h00, K_OK);
    add(0, 1, 16'h0400, 0, 0, 0, 0, 0, 8'h00, 8'h00, K_IGN);
    add(0, 1, 16'h0100, 0, 0, 0, 0, 0, 8'h00, 8'h00, K_IGN);
    add(1, 1, 16'h0010, 0, 0, 0, 0, 0, 8'h00, 8'h00, K_IGN);
    add(1, 0, 16'h0030, 2, 0, 0, 0, 0, 8'h90, 8'h01, K_OK);
    add(1, 0, 16'h0030, 2, 0, 1, 2, 0, 8'h51, 8'h01, K_OK);
    add(0, 1, 16'h0030, 2, 1, 0, 0, 0, 8'h00, 8'h00, K_OK);
    add(1, 0, 16'h0040, 3, 1, 0, 0, 0, 8'h60, 8'h03, K_OK);
    add(0, 1, 16'h0040, 3, 3, 3, 0, 3, 8'h00, 8'h00, K_OK);
    add(0, 1, 16'h0042, 0, 0, 0, 0, 0, 8'h00, 8'h00, K_OK);
    add(1, 0, 16'h0060, 2, 0, 0, 0, 0, 8'hA0, 8'h01, K_OK);
    add(1, 0, 16'h0060, 3, 2, 2, 0, 4, 8'hE0, 8'h01, K_OK);
    add(0, 1, 16'h0060, 2, 1, 0, 0, 0, 8'h00, 8'h00, K_OK);
    add(0, 1, 16'h00FF, 0, 0, 0, 0, 0, 8'h00, 8'h00, K_OK);
    add(1, 0, 16'h00FF, 1, 0, 0, 0, 0, 8'h77, 8'h01, K_ERR);
    add(0, 1, 16'h0020, 1, 7, 0, 0, 0, 8'h00, 8'h00, K_OK);
    add(0, 1, 16'h00FE, 1, 0, 5, 0, 0, 8'h00, 8'h00, K_OK);

    reset = 1'b1;
    addr = '0; size = '0; read = 1'b0; write = 1'b0; bip = 1'b0;
    data_in = '0; wait_cfg = '0;
    @(posedge clk);
    #1;
    repeat (2) begin
      exp_cyc(0, 0, 0, 8'h00);
      tick();
    end
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) do_txn(tbl[i]);

    repeat (2) begin
      exp_cyc(0, 0, 0, 8'h00);
      tick();
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
`ifdef JK_UBUS_SLAVE_STATS_EN
    chk("rd_cnt", 32'(rd_cnt), 32'(rd_exp));
    chk("wr_cnt", 32'(wr_cnt), 32'(wr_exp));
    chk("err_cnt", 32'(err_cnt), 32'(err_exp));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
